vblank_arbiter: RTL
===================

VBLANK_ARBITER -- requirements
Module: vblank_arbiter

Interface
REQ-001 The block SHALL take parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 The block SHALL take parameter MAX_HOLD, default 256: maximum grant length in pclk cycles.
REQ-003 pclk  in  1  pixel clock; the single clock of the block.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 vblnk  in  1  vertical blank from the timing generator, pclk domain; the arbitration window is open while vblnk=1.
REQ-006 req  in  N_REQ  per-requester level request for the shared framebuffer write port.
REQ-007 release  in  N_REQ  per-requester one-cycle pulse ending its own grant.
REQ-008 gnt  out  N_REQ  registered grant; one-hot or zero.
REQ-009 gnt_id  out  3  index of the granted requester; 0 when no grant.
REQ-010 busy  out  1  high while any gnt bit is high.
REQ-011 abort  out  1  one-cycle pulse when a grant is revoked by the block.
REQ-012 frame_tick  out  1  one-cycle pulse, one cycle after a vblnk rising edge.
REQ-013 miss_cnt  out  8  saturating count of windows closed with an ungranted pending request.

Function
REQ-014 The FSM SHALL have states WAIT, ARB, GRANT and GAP, with all outputs registered.
REQ-015 WAIT: gnt=0; if vblnk=1 then next state is ARB.
REQ-016 ARB: if vblnk=0 then go to WAIT; else if req is non-zero, pick a winner round-robin, starting at the index after the last winner and wrapping at N_REQ-1 to 0; else stay in ARB.
REQ-017 Grant latency SHALL be exactly 1 cycle: a request sampled in ARB at cycle t gives gnt[winner]=1, gnt_id=winner and busy=1 at cycle t+1, with state GRANT.
REQ-018 The last-winner pointer SHALL update only when a grant is issued.
REQ-019 GRANT: the hold counter starts at 0 and increments each cycle.
REQ-020 GRANT, release[gnt_id]=1: gnt clears next cycle, next state is GAP, and no abort is raised.
REQ-021 GRANT, vblnk=0 with no release: gnt clears next cycle, abort pulses once, and next state is WAIT.
REQ-022 GRANT, hold counter reaches MAX_HOLD-1 with no release: gnt clears next cycle, abort pulses once, and next state is GAP (or WAIT if vblnk=0).
REQ-023 If release and a revoke condition occur in the same cycle, release SHALL win and abort SHALL stay 0.
REQ-024 A release on a non-granted index SHALL be ignored.
REQ-025 Deasserting req during GRANT SHALL be ignored; only release or a revoke ends a grant.
REQ-026 GAP SHALL last exactly 1 idle cycle with gnt=0, then go to ARB, or to WAIT if vblnk=0.
REQ-027 On a vblnk falling edge (vblnk_q=1, vblnk=0), miss_cnt SHALL increment if (req & ~gnt) is non-zero.
REQ-028 miss_cnt SHALL saturate at 255 and never wrap.
REQ-029 frame_tick SHALL come from a registered vblnk_q edge detect, independent of FSM state.

Reset
REQ-030 While rst=0, all outputs SHALL be 0 immediately, without waiting for a pclk edge.
REQ-031 While rst=0, the state SHALL be WAIT, the hold counter 0, vblnk_q 0, and the last-winner pointer N_REQ-1, so that req[0] has first priority.
REQ-032 Reset asserted mid-grant SHALL drop gnt asynchronously and SHALL NOT produce an abort pulse.
REQ-033 After rst is released, the first grant SHALL need a vblnk=1 sample (WAIT to ARB, then ARB to GRANT).

Structure
REQ-034 The state encoding, the default N_REQ and MAX_HOLD values, and the width constants SHALL live in the shared include file vblank_arb_pkg.
REQ-035 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs req and last; outputs valid and idx), instanced once.
REQ-036 The hold counter width SHALL be clog2(MAX_HOLD).
REQ-037 No logic SHALL exist outside the pclk domain.

Verification
REQ-038 Bench case 1: with vblnk=1, req=4'b0101 held, each grant released after 3 cycles -> grants alternate id0, id2, id0, each gnt 1 cycle after ARB, with a 1-cycle GAP between grants.
REQ-039 Bench case 2: with vblnk=0, req=4'b1111 -> gnt stays 0; on vblnk rising, frame_tick pulses once and gnt=4'b0001 appears 2 cycles after the edge.
REQ-040 Bench case 3: a grant is held with no release and vblnk falls -> gnt clears next cycle, abort is a 1-cycle pulse, and miss_cnt increments only if another req is high.
REQ-041 Bench case 4: a grant is held for MAX_HOLD cycles -> abort fires at hold count 255, then GAP, then the next requester in round-robin order is granted.
REQ-042 Bench case 5: release and vblnk fall in the same cycle -> abort=0, and gnt clears next cycle.
REQ-043 Bench case 6: rst pulled low mid-grant -> gnt and busy are 0 before the next pclk edge; miss_cnt=0 and ptr=N_REQ-1 after release, so req=4'b1000 plus req[0] yields a grant to id0 first.

Source files
------------

// File: rtl/vblank_arb_pkg.sv
// rtl/vblank_arb_pkg.sv - shared types and constants for the vblank arbiter
// Contents: FSM state encoding, default requester count / hold limit,
//           grant-index and miss-counter widths.
package vblank_arb_pkg;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_MAX_HOLD = 256;
  localparam int ID_W         = 3;
  localparam int MISS_W       = 8;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/vblank_arbiter_if.sv
// rtl/vblank_arbiter_if.sv - request/grant bundle between requesters and arbiter
// Signals: req (level request), rel (one-cycle release pulse), gnt (one-hot grant),
//          gnt_id (granted index), busy (grant active), abort (grant revoked pulse).
// Modports: master = requester side, slave = arbiter side.
interface vblank_arbiter_if
  import vblank_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] rel;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             abort;

  modport master (output req, rel, input gnt, gnt_id, busy, abort);
  modport slave  (input req, rel, output gnt, gnt_id, busy, abort);
endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner selection
// Inputs:  req (request vector), last (previous winner index)
// Outputs: valid (any request), idx (first requester after last, wrapping to 0)
module rr_picker
  import vblank_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  logic            hi_found;
  logic            lo_found;
  logic [ID_W-1:0] hi_idx;
  logic [ID_W-1:0] lo_idx;

  // Lowest set index above last wins; otherwise wrap to the lowest set index
  // at or below last.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) begin
        if (i > int'(last)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = ID_W'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = ID_W'(i);
        end
      end
    end
    valid = hi_found | lo_found;
    idx   = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/vblank_arbiter.sv
// rtl/vblank_arbiter.sv - vertical-blank window arbiter for the framebuffer write port
// Ports: pclk (pixel clock), rst (async active-low reset), vblnk (window open),
//        bus (slave side of request/grant bundle), frame_tick (pulse after vblnk rise),
//        miss_cnt (saturating count of windows closed with an ungranted request).
module vblank_arbiter
  import vblank_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vblnk,
  vblank_arbiter_if.slave   bus,
  output logic              frame_tick,
  output logic [MISS_W-1:0] miss_cnt
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic              busy_q, busy_d;
  logic              abort_q, abort_d;
  logic              vblnk_q;
  logic              tick_q;
  logic [MISS_W-1:0] miss_q;

  logic              pick_valid;
  logic [ID_W-1:0]   pick_idx;
  logic              rel_hit;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req   (bus.req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Only the holder's own release counts; releases on other indices drop out here.
  assign rel_hit = |(bus.rel & gnt_q);

  always_comb begin
    state_d  = state_q;
    hold_d   = '0;
    last_d   = last_q;
    gnt_d    = '0;
    gnt_id_d = '0;
    busy_d   = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (vblnk) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (!vblnk) begin
          state_d = ST_WAIT;
        end else if (pick_valid) begin
          state_d  = ST_GRANT;
          gnt_d    = N_REQ'(1) << pick_idx;
          gnt_id_d = pick_idx;
          busy_d   = 1'b1;
          last_d   = pick_idx;
        end
      end
      ST_GRANT: begin
        // Release is checked first so it always beats a simultaneous revoke.
        if (rel_hit) begin
          state_d = ST_GAP;
        end else if (!vblnk) begin
          state_d = ST_WAIT;
          abort_d = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_GAP;
          abort_d = 1'b1;
        end else begin
          gnt_d    = gnt_q;
          gnt_id_d = gnt_id_q;
          busy_d   = 1'b1;
          hold_d   = hold_q + HOLD_W'(1);
        end
      end
      ST_GAP: begin
        state_d = vblnk ? ST_ARB : ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_WAIT;
      hold_q   <= '0;
      last_q   <= ID_W'(N_REQ - 1);
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
      abort_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      tick_q   <= 1'b0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
      abort_q  <= abort_d;
      vblnk_q  <= vblnk;
      tick_q   <= vblnk & ~vblnk_q;
      // A window closing with someone still waiting counts as a miss.
      if (vblnk_q && !vblnk && (|(bus.req & ~gnt_q)) && (miss_q != '1))
        miss_q <= miss_q + MISS_W'(1);
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = busy_q;
  assign bus.abort  = abort_q;
  assign frame_tick = tick_q;
  assign miss_cnt   = miss_q;

endmodule
